// File: rtl/ram_sdp.sv
// ram_sdp -- simple dual-port RAM (one read port, one write port) with
// byte-lane write enables and a self-clearing sweep after reset.
//
// After reset the array is swept to all-zero, one address per edge, before
// any request is accepted. o_ready reports that the sweep has finished.
//
// Optional feature: define RAM_SDP_BYPASS_EN to make a same-address
// read/write collision return the merged (new-data) word. Without it the
// read returns the word stored before the write (read-first).
module ram_sdp #(
  parameter int WORD_SIZE    = 16,
  parameter int ADDR_WIDTH   = 5,
  parameter int READ_LATENCY = 1
) (
  input  logic                    i_CLK,
  input  logic                    i_RST,
  input  logic                    i_read_en,
  input  logic [ADDR_WIDTH-1:0]   i_read_addr,
  input  logic                    i_write_en,
  input  logic [ADDR_WIDTH-1:0]   i_write_addr,
  input  logic [WORD_SIZE/8-1:0]  i_write_be,
  input  logic [WORD_SIZE-1:0]    i_write_data,
  output logic [WORD_SIZE-1:0]    o_read_data,
  output logic                    o_read_valid,
  output logic                    o_ready
);

  localparam int MEM_SIZE  = 2 ** ADDR_WIDTH;
  localparam int NUM_LANES = WORD_SIZE / 8;

  // Reject word widths that cannot be split into whole byte lanes.
  if (((WORD_SIZE % 8) != 0) || (WORD_SIZE < 8)) begin : g_bad_word_size
    $error("ram_sdp: WORD_SIZE must be a non-zero multiple of 8");
  end

  // Only one- and two-stage read pipelines exist.
  if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
    $error("ram_sdp: READ_LATENCY must be 1 or 2");
  end

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   sweep_addr;
  logic [WORD_SIZE-1:0]    mem [MEM_SIZE];

  logic                    read_accept;
  logic                    write_accept;
  logic [WORD_SIZE-1:0]    read_word;

  logic                    stage_valid;
  logic [WORD_SIZE-1:0]    stage_data;

  // Requests are only honoured once the clear sweep has completed.
  assign read_accept  = i_read_en  && o_ready;
  assign write_accept = i_write_en && o_ready;

  // Sweep controller: walk every address once after reset, then stay ready.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state      <= CLEAR;
      sweep_addr <= '0;
      o_ready    <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          sweep_addr <= sweep_addr + 1'b1;
          if (&sweep_addr) begin
            state   <= READY;
            o_ready <= 1'b1;
          end
        end
        READY: begin
          state   <= READY;
          o_ready <= 1'b1;
        end
        default: begin
          state      <= CLEAR;
          sweep_addr <= '0;
          o_ready    <= 1'b0;
        end
      endcase
    end
  end

  // Array write port: zero fill during the sweep, byte-masked writes once ready.
  always_ff @(posedge i_CLK) begin
    if (!i_RST) begin
      if (state == CLEAR) begin
        mem[sweep_addr] <= '0;
      end else if (write_accept) begin
        for (int lane = 0; lane < NUM_LANES; lane++) begin
          if (i_write_be[lane]) begin
            mem[i_write_addr][lane*8 +: 8] <= i_write_data[lane*8 +: 8];
          end
        end
      end
    end
  end

  // Word sampled at acceptance; collision handling depends on the bypass build.
  always_comb begin
    read_word = mem[i_read_addr];
`ifdef RAM_SDP_BYPASS_EN
    if (write_accept && (i_write_addr == i_read_addr)) begin
      for (int lane = 0; lane < NUM_LANES; lane++) begin
        if (i_write_be[lane]) begin
          read_word[lane*8 +: 8] = i_write_data[lane*8 +: 8];
        end
      end
    end
`endif
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                 s1_valid;
    logic [WORD_SIZE-1:0] s1_data;

    // First read stage: capture the sampled word so later writes cannot touch it.
    always_ff @(posedge i_CLK) begin
      if (i_RST) begin
        s1_valid <= 1'b0;
        s1_data  <= '0;
      end else begin
        s1_valid <= read_accept;
        if (read_accept) begin
          s1_data <= read_word;
        end
      end
    end

    assign stage_valid = s1_valid;
    assign stage_data  = s1_data;
  end else begin : g_lat1
    assign stage_valid = read_accept;
    assign stage_data  = read_word;
  end

  // Output register: pulse valid per completed read, hold data between reads.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      o_read_valid <= 1'b0;
      o_read_data  <= '0;
    end else begin
      o_read_valid <= stage_valid;
      if (stage_valid) begin
        o_read_data <= stage_data;
      end
    end
  end

endmodule

// File: tb/tb_ram_sdp.sv
// tb_ram_sdp -- self-checking bench for ram_sdp.
// Two instances (read latency 1 and 2) share the same stimulus and are both
// compared every cycle against a behavioural model of the memory.
module tb_ram_sdp;

`ifdef RAM_SDP_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        read_en;
  logic [4:0]  read_addr;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [1:0]  write_be;
  logic [15:0] write_data;

  logic [15:0] l1_data;
  logic        l1_valid;
  logic        l1_ready;
  logic [15:0] l2_data;
  logic        l2_valid;
  logic        l2_ready;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  typedef struct {
    int          due;
    logic [15:0] data;
  } pend_t;

  logic [15:0] ref_mem [32];
  pend_t       q1[$];
  pend_t       q2[$];
  int          cycle     = 0;
  int          sweep_cnt = 0;
  logic        exp_ready = 1'b0;
  logic        exp_v1    = 1'b0;
  logic        exp_v2    = 1'b0;
  logic [15:0] exp_d1    = '0;
  logic [15:0] exp_d2    = '0;

  typedef struct {
    logic [4:0]  waddr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic [4:0]  raddr;
    logic [15:0] expected;
  } vec_t;

  vec_t vecs[6];

  ram_sdp #(.WORD_SIZE(16), .ADDR_WIDTH(5), .READ_LATENCY(1)) dut_l1 (
    .i_CLK        (clk),
    .i_RST        (rst),
    .i_read_en    (read_en),
    .i_read_addr  (read_addr),
    .i_write_en   (write_en),
    .i_write_addr (write_addr),
    .i_write_be   (write_be),
    .i_write_data (write_data),
    .o_read_data  (l1_data),
    .o_read_valid (l1_valid),
    .o_ready      (l1_ready)
  );

  ram_sdp #(.WORD_SIZE(16), .ADDR_WIDTH(5), .READ_LATENCY(2)) dut_l2 (
    .i_CLK        (clk),
    .i_RST        (rst),
    .i_read_en    (read_en),
    .i_read_addr  (read_addr),
    .i_write_en   (write_en),
    .i_write_addr (write_addr),
    .i_write_be   (write_be),
    .i_write_data (write_data),
    .o_read_data  (l2_data),
    .o_read_valid (l2_valid),
    .o_ready      (l2_ready)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] mergeWord(logic [15:0] old_word, logic [15:0] new_word,
                                            logic [1:0] be);
    logic [15:0] r;
    r = old_word;
    if (be[0]) r[7:0]  = new_word[7:0];
    if (be[1]) r[15:8] = new_word[15:8];
    return r;
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Advance the model by one clock edge using the inputs sampled there
  task automatic modelEdge();
    logic [15:0] word;
    cycle++;
    if (rst) begin
      q1.delete();
      q2.delete();
      sweep_cnt = 0;
      exp_v1 = 1'b0;
      exp_v2 = 1'b0;
      exp_d1 = '0;
      exp_d2 = '0;
    end else begin
      if (sweep_cnt < 32) begin
        ref_mem[sweep_cnt] = '0;
        sweep_cnt++;
      end else begin
        if (read_en) begin
          word = ref_mem[read_addr];
          if (BYPASS && write_en && (write_addr == read_addr))
            word = mergeWord(word, write_data, write_be);
          q1.push_back('{cycle, word});
          q2.push_back('{cycle + 1, word});
        end
        if (write_en)
          ref_mem[write_addr] = mergeWord(ref_mem[write_addr], write_data, write_be);
      end
      exp_v1 = 1'b0;
      if (q1.size() > 0 && q1[0].due == cycle) begin
        exp_v1 = 1'b1;
        exp_d1 = q1[0].data;
        q1.delete(0);
      end
      exp_v2 = 1'b0;
      if (q2.size() > 0 && q2[0].due == cycle) begin
        exp_v2 = 1'b1;
        exp_d2 = q2[0].data;
        q2.delete(0);
      end
    end
    exp_ready = (sweep_cnt >= 32);
  endtask

  task automatic compareModel();
    checkOutput("l1_ready", 32'(l1_ready), 32'(exp_ready));
    checkOutput("l1_valid", 32'(l1_valid), 32'(exp_v1));
    checkOutput("l1_data",  32'(l1_data),  32'(exp_d1));
    checkOutput("l2_ready", 32'(l2_ready), 32'(exp_ready));
    checkOutput("l2_valid", 32'(l2_valid), 32'(exp_v2));
    checkOutput("l2_data",  32'(l2_data),  32'(exp_d2));
  endtask

  task automatic applyStimulus(logic r, logic re, logic [4:0] ra, logic we, logic [4:0] wa,
                               logic [1:0] be, logic [15:0] wd);
    @(negedge clk);
    rst        = r;
    read_en    = re;
    read_addr  = ra;
    write_en   = we;
    write_addr = wa;
    write_be   = be;
    write_data = wd;
    @(posedge clk);
    modelEdge();
    #1;
    compareModel();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 2'b00, 16'h0000);
  endtask

  // Read (optionally with a concurrent write) and check both latencies explicitly
  task automatic readWrite(string name, logic [4:0] ra, logic we, logic [4:0] wa,
                           logic [1:0] be, logic [15:0] wd, logic [15:0] expected);
    applyStimulus(1'b0, 1'b1, ra, we, wa, be, wd);
    checkOutput({name, "_l1_valid"}, 32'(l1_valid), 32'd1);
    checkOutput({name, "_l1_data"},  32'(l1_data),  32'(expected));
    checkOutput({name, "_l2_early"}, 32'(l2_valid), 32'd0);
    idle();
    checkOutput({name, "_l2_valid"}, 32'(l2_valid), 32'd1);
    checkOutput({name, "_l2_data"},  32'(l2_data),  32'(expected));
    checkOutput({name, "_l1_pulse"}, 32'(l1_valid), 32'd0);
  endtask

  // Hold reset then release it, checking o_ready rises on exactly the 32nd edge
  task automatic resetAndSweep(string name, int poke_cycle);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 2'b00, 16'h0000);
    checkOutput({name, "_rst_ready"}, 32'(l1_ready), 32'd0);
    checkOutput({name, "_rst_valid"}, 32'(l2_valid), 32'd0);
    checkOutput({name, "_rst_data"},  32'(l1_data),  32'd0);
    for (int i = 1; i <= 32; i++) begin
      if (i == poke_cycle)
        applyStimulus(1'b0, 1'b1, 5'd31, 1'b1, 5'd31, 2'b11, 16'hFFFF);
      else
        idle();
      checkOutput({name, "_sweep_ready"}, 32'(l1_ready), (i == 32) ? 32'd1 : 32'd0);
      checkOutput({name, "_sweep_valid"}, 32'(l1_valid | l2_valid), 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{5'd5,  2'b11, 16'hBEEF, 5'd5,  16'hBEEF};
    vecs[1] = '{5'd5,  2'b01, 16'h1234, 5'd5,  16'hBE34};
    vecs[2] = '{5'd5,  2'b00, 16'hFFFF, 5'd5,  16'hBE34};
    vecs[3] = '{5'd9,  2'b10, 16'hABCD, 5'd9,  16'hAB00};
    vecs[4] = '{5'd10, 2'b11, 16'h0F0F, 5'd9,  16'hAB00};
    vecs[5] = '{5'd31, 2'b11, 16'h0001, 5'd31, 16'h0001};

    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    rst = 1'b1; read_en = 1'b0; read_addr = '0; write_en = 1'b0;
    write_addr = '0; write_be = '0; write_data = '0;

    $display("[TB] reset and clear sweep (write/read poked on sweep edge 3)");
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 2'b00, 16'h0000);
    resetAndSweep("sweep", 3);

    $display("[TB] back-to-back reads of the cleared array");
    for (int a = 0; a < 32; a++) begin
      applyStimulus(1'b0, 1'b1, 5'(a), 1'b0, 5'd0, 2'b00, 16'h0000);
      checkOutput("clear_l1_valid", 32'(l1_valid), 32'd1);
      checkOutput("clear_l1_data",  32'(l1_data),  32'd0);
    end
    idle();
    checkOutput("clear_l2_last", 32'(l2_data), 32'd0);

    $display("[TB] table-driven write/read vectors");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, vecs[i].waddr, vecs[i].be, vecs[i].wdata);
      readWrite("vec", vecs[i].raddr, 1'b0, 5'd0, 2'b00, 16'h0000, vecs[i].expected);
    end

    $display("[TB] simultaneous read/write and collisions");
    readWrite("diff_addr", 5'd5, 1'b1, 5'd12, 2'b11, 16'h7777, 16'hBE34);
    readWrite("diff_after", 5'd12, 1'b0, 5'd0, 2'b00, 16'h0000, 16'h7777);
    readWrite("collide_full", 5'd7, 1'b1, 5'd7, 2'b11, 16'hA5A5,
              BYPASS ? 16'hA5A5 : 16'h0000);
    readWrite("collide_after", 5'd7, 1'b0, 5'd0, 2'b00, 16'h0000, 16'hA5A5);
    readWrite("collide_lane", 5'd7, 1'b1, 5'd7, 2'b01, 16'h1234,
              BYPASS ? 16'hA534 : 16'hA5A5);
    idle();
    checkOutput("hold_l1_data", 32'(l1_data), BYPASS ? 32'h0000A534 : 32'h0000A5A5);

    $display("[TB] reset while a read is in flight");
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 5'd2, 2'b11, 16'h5555);
    applyStimulus(1'b0, 1'b1, 5'd2, 1'b0, 5'd0, 2'b00, 16'h0000);
    checkOutput("flight_l1_data", 32'(l1_data), 32'h00005555);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'd3, 2'b11, 16'h9999);
    checkOutput("flight_l2_valid", 32'(l2_valid), 32'd0);
    checkOutput("flight_l2_ready", 32'(l2_ready), 32'd0);
    resetAndSweep("resweep", 0);
    readWrite("after_rst_a2", 5'd2, 1'b0, 5'd0, 2'b00, 16'h0000, 16'h0000);
    readWrite("after_rst_a3", 5'd3, 1'b0, 5'd0, 2'b00, 16'h0000, 16'h0000);

    $display("[TB] reset mid-sweep restarts at address 0");
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 5'd20, 2'b11, 16'h4242);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 2'b00, 16'h0000);
    for (int i = 0; i < 10; i++) idle();
    resetAndSweep("midsweep", 0);
    readWrite("midsweep_a20", 5'd20, 1'b0, 5'd0, 2'b00, 16'h0000, 16'h0000);

    $display("[TB] randomized traffic against the reference model");
    for (int n = 0; n < 600; n++) begin
      logic        r;
      logic [4:0]  ra;
      logic [4:0]  wa;
      r  = ($urandom_range(0, 149) == 0);
      ra = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      wa = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      applyStimulus(r, 1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa,
                    2'($urandom_range(0, 3)), 16'($urandom));
    end
    for (int i = 0; i < 3; i++) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
